// File: rtl/cart_mem_arbiter.sv
// cart_mem_arbiter: shares one single-port cartridge memory between the ROM loader write stream and console reads
// Ports:
//   clk_i, reset_n_i                     clock, synchronous active-low reset
//   ioctl_download/wr/addr/dout          loader stream in; ioctl_wait back-pressure out
//   cart_rd_i, cart_a_i                  console read strobe/address in
//   cart_d_o, cart_valid_o               read data (held) and one-cycle completion pulse
//   cart_pages_o                         highest 16KB page written since last addr-0 write
//   mem_busy_i/req_o/we_o/addr_o/din_o   memory command interface
//   mem_dout_i, mem_ack_i                memory read completion
//   err_o                                sticky: dropped loader write or read timeout
module cart_mem_arbiter #(
    parameter int AW      = 20,
    parameter int TIMEOUT = 255
) (
    input  logic          clk_i,
    input  logic          reset_n_i,
    input  logic          ioctl_download,
    input  logic          ioctl_wr,
    input  logic [AW-1:0] ioctl_addr,
    input  logic [7:0]    ioctl_dout,
    output logic          ioctl_wait,
    input  logic          cart_rd_i,
    input  logic [AW-1:0] cart_a_i,
    output logic [7:0]    cart_d_o,
    output logic          cart_valid_o,
    output logic [5:0]    cart_pages_o,
    input  logic          mem_busy_i,
    output logic          mem_req_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [7:0]    mem_din_o,
    input  logic [7:0]    mem_dout_i,
    input  logic          mem_ack_i,
    output logic          err_o
);
    localparam int CW = $clog2(TIMEOUT);
    typedef enum logic [1:0] {IDLE, WR, RD, RD_WAIT} state_t;
    state_t        state_q, state_d;
    logic          wbuf_valid_q, wbuf_valid_d;
    logic [AW-1:0] wbuf_addr_q, wbuf_addr_d;
    logic [7:0]    wbuf_data_q, wbuf_data_d;
    logic          rd_pend_q, rd_pend_d;
    logic [AW-1:0] rd_addr_q, rd_addr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    cart_d_q, cart_d_d;
    logic          cart_valid_q, cart_valid_d;
    logic [5:0]    pages_q, pages_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]    mem_din_q, mem_din_d;
    logic          err_q, err_d;
    logic          wr_acc;
    always_comb begin
        wr_acc       = ioctl_wr && !wbuf_valid_q;
        state_d      = state_q;
        wbuf_valid_d = wbuf_valid_q || wr_acc;
        wbuf_addr_d  = wr_acc ? ioctl_addr : wbuf_addr_q;
        wbuf_data_d  = wr_acc ? ioctl_dout : wbuf_data_q;
        pages_d      = !wr_acc ? pages_q :
                       (ioctl_addr == '0) ? 6'd0 :
                       (ioctl_addr[19:14] > pages_q) ? ioctl_addr[19:14] : pages_q;
        err_d        = err_q || (ioctl_wr && wbuf_valid_q);
        // a new console strobe always becomes the pending read; loader activity discards it
        rd_pend_d    = ioctl_download ? 1'b0 : (cart_rd_i || rd_pend_q);
        rd_addr_d    = (cart_rd_i && !ioctl_download) ? cart_a_i : rd_addr_q;
        cart_valid_d = cart_rd_i && ioctl_download;
        cart_d_d     = (cart_rd_i && ioctl_download) ? 8'hFF : cart_d_q;
        cnt_d        = cnt_q;
        mem_req_d    = 1'b0;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_din_d    = mem_din_q;
        case (state_q)
            IDLE: begin
                if (wbuf_valid_q && !mem_busy_i) begin
                    state_d    = WR;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b1;
                    mem_addr_d = wbuf_addr_q;
                    mem_din_d  = wbuf_data_q;
                end else if (rd_pend_q && !mem_busy_i && !ioctl_download) begin
                    state_d    = RD;
                    mem_req_d  = 1'b1;
                    mem_addr_d = rd_addr_q;
                    rd_pend_d  = cart_rd_i;
                end
            end
            WR: begin
                state_d      = IDLE;
                wbuf_valid_d = 1'b0;
            end
            RD: begin
                state_d = RD_WAIT;
                cnt_d   = '0;
            end
            default: begin
                if (mem_ack_i) begin
                    state_d      = IDLE;
                    cart_d_d     = mem_dout_i;
                    cart_valid_d = 1'b1;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d      = IDLE;
                    cart_d_d     = 8'hFF;
                    cart_valid_d = 1'b1;
                    err_d        = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        endcase
    end
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q      <= IDLE;
            wbuf_valid_q <= 1'b0;
            wbuf_addr_q  <= '0;
            wbuf_data_q  <= '0;
            rd_pend_q    <= 1'b0;
            rd_addr_q    <= '0;
            cnt_q        <= '0;
            cart_d_q     <= 8'hFF;
            cart_valid_q <= 1'b0;
            pages_q      <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_din_q    <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            wbuf_valid_q <= wbuf_valid_d;
            wbuf_addr_q  <= wbuf_addr_d;
            wbuf_data_q  <= wbuf_data_d;
            rd_pend_q    <= rd_pend_d;
            rd_addr_q    <= rd_addr_d;
            cnt_q        <= cnt_d;
            cart_d_q     <= cart_d_d;
            cart_valid_q <= cart_valid_d;
            pages_q      <= pages_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_din_q    <= mem_din_d;
            err_q        <= err_d;
        end
    end
    assign ioctl_wait   = wbuf_valid_q;
    assign cart_d_o     = cart_d_q;
    assign cart_valid_o = cart_valid_q;
    assign cart_pages_o = pages_q;
    assign mem_req_o    = mem_req_q;
    assign mem_we_o     = mem_we_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_din_o    = mem_din_q;
    assign err_o        = err_q;
endmodule
